pingpong_sample_ctrl: RTL and testbench

Scheduler for the two audio sample banks (bank 0 and bank 1) that feed the FFT. It steers incoming codec samples into whichever bank is free and hands each filled bank to the FFT as one contiguous read burst. It releases the bank once the burst ends and counts frames and dropped samples. It sits between the audio codec interface, the dual sample RAM banks and the FFT input port, and takes over all bank sequencing from the top-level control FSM.

---
 rtl/pingpong_sample_ctrl_if.sv | 50 +++++
 rtl/pingpong_sample_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pingpong_sample_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_sample_ctrl_if.sv
// ---------------------------------------------------------------------------
// pingpong_sample_ctrl_if
//
// Groups the codec-side, RAM-side and FFT-side signals of the ping-pong
// sample bank scheduler.
//   master : the scheduler itself. It drives the write/read strobes,
//            addresses, bank flags and counters.
//   slave  : the surrounding system. It drives enable, sample_valid and
//            fft_ready, and observes everything else.
// Parameters match the scheduler:
//   DEPTH_LOG2 : log2 of the number of samples per bank.
//   CNT_W      : width of the frame and drop counters.
// ---------------------------------------------------------------------------
interface pingpong_sample_ctrl_if #(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_W      = 16
);
  // Codec / write side
  logic                  enable;
  logic                  sample_valid;
  logic                  wr_en;
  logic                  wr_bank;
  logic [DEPTH_LOG2-1:0] wr_addr;
  // FFT / read side
  logic                  fft_ready;
  logic                  fft_start;
  logic                  rd_en;
  logic                  rd_bank;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  rd_last;
  // Status
  logic [1:0]            bank_full;
  logic [CNT_W-1:0]      frame_count;
  logic [CNT_W-1:0]      drop_count;
  logic                  overflow;

  modport master (
    input  enable, sample_valid, fft_ready,
    output wr_en, wr_bank, wr_addr,
    output fft_start, rd_en, rd_bank, rd_addr, rd_last,
    output bank_full, frame_count, drop_count, overflow
  );

  modport slave (
    output enable, sample_valid, fft_ready,
    input  wr_en, wr_bank, wr_addr,
    input  fft_start, rd_en, rd_bank, rd_addr, rd_last,
    input  bank_full, frame_count, drop_count, overflow
  );
endinterface

// File: rtl/pingpong_sample_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_sample_ctrl
//
// Scheduler for two audio sample banks feeding the FFT. Incoming codec
// samples are written into the bank that is free. Each bank that fills up
// is handed to the FFT as one contiguous read burst. The bank is then
// released. The block also counts delivered frames and dropped samples.
//
// Ports:
//   clk    : system clock, all logic on the rising edge.
//   reset  : synchronous, active-low reset.
//   bus    : pingpong_sample_ctrl_if.master. It carries:
//     enable, sample_valid        (in)  codec capture enable / sample strobe
//     wr_en, wr_bank, wr_addr     (out) bank write port; wr_en is combinational
//     fft_ready                   (in)  FFT can accept a new frame
//     fft_start                   (out) one-cycle pulse before each burst
//     rd_en, rd_bank, rd_addr,
//     rd_last                     (out) bank read burst
//     bank_full                   (out) per-bank full flags
//     frame_count                 (out) frames delivered, wraps
//     drop_count                  (out) samples dropped, saturates
//     overflow                    (out) sticky, set on the first drop
// ---------------------------------------------------------------------------
module pingpong_sample_ctrl #(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pingpong_sample_ctrl_if.master bus
);

  localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    RELEASE
  } rd_state_e;

  // State registers
  rd_state_e             state_q,       state_d;
  logic                  wr_bank_q,     wr_bank_d;
  logic [DEPTH_LOG2-1:0] wr_addr_q,     wr_addr_d;
  logic                  rd_bank_q,     rd_bank_d;
  logic [DEPTH_LOG2-1:0] rd_addr_q,     rd_addr_d;
  logic [1:0]            bank_full_q,   bank_full_d;
  logic [CNT_W-1:0]      frame_count_q, frame_count_d;
  logic [CNT_W-1:0]      drop_count_q,  drop_count_d;
  logic                  overflow_q,    overflow_d;

  // Writer/reader handshake on the full flags
  logic                  wr_en;
  logic                  drop;
  logic [1:0]            set_full;
  logic [1:0]            clr_full;

  // -------------------------------------------------------------------------
  // Writer: fills wr_bank and marks it full on its last address.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first. Without it, any
    // path that skips an assignment would infer a latch.
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    set_full     = 2'b00;

    wr_en = bus.sample_valid & bus.enable & ~bank_full_q[wr_bank_q];
    drop  = bus.sample_valid & bus.enable &  bank_full_q[wr_bank_q];

    if (wr_en) begin
      if (wr_addr_q == ADDR_LAST) begin
        set_full[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_addr_d           = '0;
      end else begin
        wr_addr_d = wr_addr_q + DEPTH_LOG2'(1);
      end
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reader FSM: waits for a full bank, then streams it to the FFT.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    rd_bank_d     = rd_bank_q;
    rd_addr_d     = rd_addr_q;
    frame_count_d = frame_count_q;
    clr_full      = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q] && bus.fft_ready) begin
          state_d = START;
        end
      end
      // fft_ready is deliberately not rechecked once a frame is committed.
      START: begin
        rd_addr_d = '0;
        state_d   = READ;
      end
      READ: begin
        if (rd_addr_q == ADDR_LAST) begin
          rd_addr_d = '0;
          state_d   = RELEASE;
        end else begin
          rd_addr_d = rd_addr_q + DEPTH_LOG2'(1);
        end
      end
      RELEASE: begin
        clr_full[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        frame_count_d       = frame_count_q + CNT_W'(1);
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The banks alternate strictly. A writer set and a reader clear in the
  // same cycle therefore always target different bits, and both apply.
  assign bank_full_d = (bank_full_q & ~clr_full) | set_full;

  // -------------------------------------------------------------------------
  // State registers, synchronous active-low reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together at the edge, independent of statement order.
    if (!reset) begin
      state_q       <= IDLE;
      wr_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      rd_bank_q     <= 1'b0;
      rd_addr_q     <= '0;
      bank_full_q   <= 2'b00;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      rd_bank_q     <= rd_bank_d;
      rd_addr_q     <= rd_addr_d;
      bank_full_q   <= bank_full_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Only wr_en is combinational from inputs. The read-side strobes
  // decode the registered state, so reset forces them low.
  // -------------------------------------------------------------------------
  assign bus.wr_en       = wr_en;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.fft_start   = (state_q == START);
  assign bus.rd_en       = (state_q == READ);
  assign bus.rd_bank     = rd_bank_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_last     = (state_q == READ) && (rd_addr_q == ADDR_LAST);
  assign bus.bank_full   = bank_full_q;
  assign bus.frame_count = frame_count_q;
  assign bus.drop_count  = drop_count_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_pingpong_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_sample_ctrl
//
// Directed bench for pingpong_sample_ctrl with 8-sample banks and 4-bit
// counters. Inputs change 1 ns after each rising edge. Registered outputs
// are observed at that point, and wr_en is observed after the inputs settle.
// ---------------------------------------------------------------------------
module tb_pingpong_sample_ctrl;

  localparam int DEPTH_LOG2 = 3;
  localparam int CNT_W      = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  pingpong_sample_ctrl_if #(.DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) bus ();

  pingpong_sample_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present n consecutive samples, one per cycle.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b1;
      step();
    end
    bus.sample_valid = 1'b0;
  endtask

  // Call in the START cycle. Walks the READ cycles and returns in RELEASE.
  task automatic burst(input string tag, input logic bank);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      check({tag, "_rd_en"},   bus.rd_en,   1);
      check({tag, "_rd_bank"}, bus.rd_bank, bank);
      check({tag, "_rd_addr"}, bus.rd_addr, i);
      check({tag, "_rd_last"}, bus.rd_last, (i == DEPTH - 1));
      step();
    end
    check({tag, "_release_rd_en"}, bus.rd_en, 0);
  endtask

  int n_frames;

  initial begin
    bus.enable       = 1'b0;
    bus.sample_valid = 1'b1;
    bus.fft_ready    = 1'b1;

    // ---- Reset, held for two edges with sample_valid high and enable low ----
    step();
    bus.fft_ready = 1'b0;
    step();
    check("rst_wr_en",       bus.wr_en,       0);
    check("rst_wr_bank",     bus.wr_bank,     0);
    check("rst_wr_addr",     bus.wr_addr,     0);
    check("rst_rd_bank",     bus.rd_bank,     0);
    check("rst_rd_addr",     bus.rd_addr,     0);
    check("rst_fft_start",   bus.fft_start,   0);
    check("rst_rd_en",       bus.rd_en,       0);
    check("rst_rd_last",     bus.rd_last,     0);
    check("rst_bank_full",   bus.bank_full,   0);
    check("rst_frame_count", bus.frame_count, 0);
    check("rst_drop_count",  bus.drop_count,  0);
    check("rst_overflow",    bus.overflow,    0);

    // ---- Single frame ----
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.enable       = 1'b1;
    bus.fft_ready    = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      bus.sample_valid = 1'b1;
      #1;
      check("sf_wr_en",   bus.wr_en,   1);
      check("sf_wr_addr", bus.wr_addr, i);
      check("sf_wr_bank", bus.wr_bank, 0);
      step();
    end
    bus.sample_valid = 1'b0;
    check("sf_full_after_e0", bus.bank_full, 2'b01);
    check("sf_wr_bank_tog",   bus.wr_bank,   1);
    check("sf_wr_addr_wrap",  bus.wr_addr,   0);
    check("sf_no_start_yet",  bus.fft_start, 0);
    step();
    check("sf_fft_start", bus.fft_start, 1);
    burst("sf", 1'b0);
    check("sf_full_in_release", bus.bank_full, 2'b01);
    step();
    check("sf_frame_count", bus.frame_count, 1);
    check("sf_bank_full",   bus.bank_full,   2'b00);
    check("sf_wr_bank",     bus.wr_bank,     1);
    check("sf_rd_bank",     bus.rd_bank,     1);

    // ---- Overflow with the FFT stalled ----
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.fft_ready = 1'b0;
    feed(2 * DEPTH);
    check("ov_bank_full_11", bus.bank_full, 2'b11);
    check("ov_no_start",     bus.fft_start, 0);
    bus.sample_valid = 1'b1;
    #1;
    check("ov_17th_wr_en", bus.wr_en, 0);
    step();
    bus.sample_valid = 1'b0;
    check("ov_drop_count", bus.drop_count, 1);
    check("ov_overflow",   bus.overflow,   1);
    check("ov_wr_addr",    bus.wr_addr,    0);
    bus.fft_ready = 1'b1;
    step();
    check("ov_start0", bus.fft_start, 1);
    burst("ov_b0", 1'b0);
    step();
    check("ov_mid_full", bus.bank_full,   2'b10);
    check("ov_mid_fc",   bus.frame_count, 1);
    step();
    check("ov_start1_b2b", bus.fft_start, 1);
    check("ov_start1_bank", bus.rd_bank,  1);
    burst("ov_b1", 1'b1);
    step();
    check("ov_frame_count", bus.frame_count, 2);
    check("ov_bank_full",   bus.bank_full,   2'b00);
    check("ov_sticky",      bus.overflow,    1);

    // ---- Writer set and reader clear on the same edge ----
    reset = 1'b0;
    step();
    reset = 1'b1;
    feed(DEPTH);              // E0: bank 0 full
    step();                   // E1: START
    step();                   // E2: READ
    step();                   // E3
    feed(DEPTH - 1);          // E4..E10: bank 1 addresses 0..6, RELEASE after E10
    check("sc_release_rd_en", bus.rd_en,     0);
    check("sc_release_full",  bus.bank_full, 2'b01);
    check("sc_wr_addr",       bus.wr_addr,   DEPTH - 1);
    bus.sample_valid = 1'b1;
    step();                   // E11: bank 1 completes, bank 0 released
    bus.sample_valid = 1'b0;
    check("sc_full_10",      bus.bank_full,   2'b10);
    check("sc_frame_count",  bus.frame_count, 1);
    check("sc_idle_nostart", bus.fft_start,   0);
    step();
    check("sc_start_b1",      bus.fft_start, 1);
    check("sc_start_b1_bank", bus.rd_bank,   1);
    burst("sc_b1", 1'b1);
    step();
    check("sc_frame_count2", bus.frame_count, 2);

    // ---- Enable low mid-bank, then reset mid-READ ----
    feed(4);
    bus.enable       = 1'b0;
    bus.sample_valid = 1'b1;
    #1;
    check("en_low_wr_en", bus.wr_en, 0);
    step();
    step();
    check("en_low_wr_addr", bus.wr_addr,    4);
    check("en_low_no_drop", bus.drop_count, 0);
    bus.enable = 1'b1;
    feed(DEPTH - 4);
    check("en_resume_full", bus.bank_full, 2'b01);
    step();                   // START
    step();                   // READ, addr 0
    step();
    step();
    step();
    check("mr_rd_addr3", bus.rd_addr, 3);
    check("mr_rd_en",    bus.rd_en,   1);
    reset = 1'b0;
    step();
    check("mr_rd_en_low",   bus.rd_en,       0);
    check("mr_rd_addr",     bus.rd_addr,     0);
    check("mr_frame_count", bus.frame_count, 0);
    check("mr_bank_full",   bus.bank_full,   2'b00);
    reset = 1'b1;

    // ---- Counter saturation and wrap ----
    bus.fft_ready = 1'b0;
    feed(2 * DEPTH);
    feed(14);
    check("sat_drop_14", bus.drop_count, 14);
    feed(6);
    check("sat_drop_15", bus.drop_count, 15);
    check("sat_overflow", bus.overflow,  1);
    bus.fft_ready    = 1'b1;
    bus.sample_valid = 1'b1;
    n_frames = 0;
    for (int c = 0; c < 600 && n_frames < 17; c++) begin
      step();
      if (bus.rd_last === 1'b1) n_frames++;
    end
    bus.sample_valid = 1'b0;
    bus.fft_ready    = 1'b0;
    check("sat_frames_seen", n_frames, 17);
    step();                   // RELEASE
    step();                   // IDLE, count updated
    check("wrap_frame_count", bus.frame_count, 17 % (1 << CNT_W));
    check("sat_drop_hold",    bus.drop_count,  15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
